rx_sample_fifo: RTL and testbench

//  Buffers 32-bit IQ words produced by the RX chain's AXI-stream output until

---
 rtl/rx_pkg.sv | 7 +
 rtl/rx_fifo_ram.sv | 39 +++
 rtl/rx_sample_fifo.sv | 121 ++++++++++++
 tb/tb_rx_sample_fifo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared RX-chain constants: sample width, default FIFO depth exponent and
// drop counter width.
package rx_pkg;
  localparam int RX_DATA_W      = 32;
  localparam int RX_FIFO_ADDR_W = 10;
  localparam int RX_DROP_W      = 16;
endpackage

// File: rtl/rx_fifo_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port, single
// clock. The read register has a synchronous reset so it maps onto the BRAM SSR.
module rx_fifo_ram
  import rx_pkg::*;
#(
  parameter int ADDR_W = RX_FIFO_ADDR_W,
  parameter int DATA_W = RX_DATA_W
) (
  input  logic              clk,
  input  logic              rd_srst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its value between accepted reads.
  always_ff @(posedge clk) begin
    if (rd_srst) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/rx_sample_fifo.sv
// Sample FIFO between the RX chain AXI-stream output and the register bus.
// Never stalls upstream: drops on full and reports overflow/underflow instead.
module rx_sample_fifo
  import rx_pkg::*;
#(
  parameter int ADDR_W = RX_FIFO_ADDR_W,
  parameter int DATA_W = RX_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 clear_i,
  input  logic                 rd_en_i,
  output logic [DATA_W-1:0]    rd_data_o,
  output logic                 rd_valid_o,
  output logic [ADDR_W:0]      count_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 overflow_o,
  output logic                 underflow_o,
  output logic [RX_DROP_W-1:0] drop_cnt_o
);

  localparam logic [ADDR_W:0]      DEPTH_CNT = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [RX_DROP_W-1:0] DROP_MAX  = '1;

  logic [ADDR_W-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]      count_reg, count_next;
  logic                 overflow_reg, overflow_next;
  logic                 underflow_reg, underflow_next;
  logic                 rd_valid_reg, rd_valid_next;
  logic [RX_DROP_W-1:0] drop_cnt_reg, drop_cnt_next;
  logic                 full, empty, wr_acc, rd_acc, wr_drop;

  assign full  = (count_reg == DEPTH_CNT);
  assign empty = (count_reg == '0);

  // Both requests judge the pre-edge count; clear overrides either.
  assign wr_acc  = s_axis_tvalid & ~full  & ~clear_i & ~rst;
  assign rd_acc  = rd_en_i       & ~empty & ~clear_i & ~rst;
  assign wr_drop = s_axis_tvalid & full;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    rd_valid_next  = 1'b0;
    drop_cnt_next  = drop_cnt_reg;
    if (clear_i) begin
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      count_next     = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
      drop_cnt_next  = '0;
    end else begin
      if (wr_acc) wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
      if (rd_acc) rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
      rd_valid_next = rd_acc;
      case ({wr_acc, rd_acc})
        2'b10:   count_next = count_reg + (ADDR_W+1)'(1);
        2'b01:   count_next = count_reg - (ADDR_W+1)'(1);
        default: count_next = count_reg;
      endcase
      if (wr_drop) begin
        overflow_next = 1'b1;
        if (drop_cnt_reg != DROP_MAX) drop_cnt_next = drop_cnt_reg + RX_DROP_W'(1);
      end
      if (rd_en_i && empty) underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      rd_valid_reg  <= 1'b0;
      drop_cnt_reg  <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      rd_valid_reg  <= rd_valid_next;
      drop_cnt_reg  <= drop_cnt_next;
    end
  end

  rx_fifo_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk    (clk),
    .rd_srst(rst | clear_i),
    .we     (wr_acc),
    .waddr  (wr_ptr_reg),
    .wdata  (s_axis_tdata),
    .re     (rd_acc),
    .raddr  (rd_ptr_reg),
    .rdata  (rd_data_o)
  );

  assign s_axis_tready = ~full;
  assign empty_o       = empty;
  assign full_o        = full;
  assign count_o       = count_reg;
  assign rd_valid_o    = rd_valid_reg;
  assign overflow_o    = overflow_reg;
  assign underflow_o   = underflow_reg;
  assign drop_cnt_o    = drop_cnt_reg;

endmodule

// File: tb/tb_rx_sample_fifo.sv
// Self-checking bench for rx_sample_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_rx_sample_fifo;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        clear_i = 1'b0;
  logic        rd_en_i = 1'b0;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic [10:0] count_o;
  logic        empty_o, full_o, overflow_o, underflow_o;
  logic [15:0] drop_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  logic [31:0] mq[$];
  logic [31:0] m_rd_data = '0;
  bit          m_rd_valid = 0;
  bit          m_ovf = 0;
  bit          m_unf = 0;
  int          m_drop = 0;

  always #5 clk = ~clk;

  rx_sample_fifo dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .clear_i(clear_i), .rd_en_i(rd_en_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .count_o(count_o),
    .empty_o(empty_o), .full_o(full_o), .overflow_o(overflow_o), .underflow_o(underflow_o),
    .drop_cnt_o(drop_cnt_o)
  );

  // Drive one cycle of inputs, advance one clock, update the model, settle.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic c);
    bit was_full, was_empty;
    s_axis_tvalid = v; s_axis_tdata = d; rd_en_i = r; clear_i = c;
    @(posedge clk);
    if (rst || c) begin
      mq.delete(); m_rd_data = '0; m_rd_valid = 0; m_ovf = 0; m_unf = 0; m_drop = 0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      m_rd_valid = 0;
      if (r && !was_empty) begin m_rd_data = mq.pop_front(); m_rd_valid = 1; end
      if (r && was_empty) m_unf = 1;
      if (v && !was_full) mq.push_back(d);
      if (v && was_full) begin m_ovf = 1; if (m_drop < 16'hFFFF) m_drop++; end
    end
    #1;
    s_axis_tvalid = 1'b0; rd_en_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (count_o !== 11'd0 || empty_o !== 1'b1 || full_o !== 1'b0 || s_axis_tready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_status: count=%0d empty=%b full=%b tready=%b, want 0 1 0 1",
               count_o, empty_o, full_o, s_axis_tready);
    end
    n_checks++;
    if (rd_valid_o !== 1'b0 || overflow_o !== 1'b0 || underflow_o !== 1'b0 ||
        drop_cnt_o !== 16'd0 || rd_data_o !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_regs: rv=%b ovf=%b unf=%b drop=%0d data=%h, want all 0",
               rd_valid_o, overflow_o, underflow_o, drop_cnt_o, rd_data_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [31:0] base = 32'h11110000;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, base + 32'(i), 1'b0, 1'b0);
    n_checks++;
    if (count_o !== 11'd4) begin
      n_errors++; $display("FAIL basic_count4: count=%0d want 4", count_o);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      n_checks++;
      if (rd_valid_o !== 1'b1 || rd_data_o !== base + 32'(i) || count_o !== 11'(3 - i)) begin
        n_errors++;
        $display("FAIL basic_read%0d: rv=%b data=%h count=%0d, want 1 %h %0d",
                 i, rd_valid_o, rd_data_o, count_o, base + 32'(i), 3 - i);
      end
      $display("basic read %0d data=%h", i, rd_data_o);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    n_checks++;
    if (empty_o !== 1'b1 || rd_valid_o !== 1'b0) begin
      n_errors++; $display("FAIL basic_empty: empty=%b rv=%b want 1 0", empty_o, rd_valid_o);
    end
  endtask

  task automatic test_fill_overflow();
    logic [31:0] first;
    do_reset();
    first = $urandom;
    cycle(1'b1, first, 1'b0, 1'b0);
    for (int i = 1; i < DEPTH + 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    n_checks++;
    if (full_o !== 1'b1 || s_axis_tready !== 1'b0 || overflow_o !== 1'b1 ||
        drop_cnt_o !== 16'd3 || count_o !== 11'd1024) begin
      n_errors++;
      $display("FAIL fill_overflow: full=%b tready=%b ovf=%b drop=%0d count=%0d, want 1 0 1 3 1024",
               full_o, s_axis_tready, overflow_o, drop_cnt_o, count_o);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== first || count_o !== 11'd1023) begin
      n_errors++;
      $display("FAIL fill_first_read: rv=%b data=%h count=%0d, want 1 %h 1023",
               rd_valid_o, rd_data_o, count_o, first);
    end
    $display("fill/overflow first word=%h", rd_data_o);
  endtask

  task automatic test_underflow();
    logic [31:0] w;
    do_reset();
    w = $urandom;
    cycle(1'b1, w, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++;
    if (rd_valid_o !== 1'b0 || underflow_o !== 1'b1 || count_o !== 11'd0 || rd_data_o !== w) begin
      n_errors++;
      $display("FAIL underflow: rv=%b unf=%b count=%0d data=%h, want 0 1 0 %h",
               rd_valid_o, underflow_o, count_o, rd_data_o, w);
    end
    $display("underflow unf=%b data=%h", underflow_o, rd_data_o);
  endtask

  task automatic test_stream();
    int bad = 0;
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 2 * DEPTH; i++) begin
      cycle(1'b1, $urandom, 1'b1, 1'b0);
      n_checks++;
      if (count_o !== 11'd1023 || rd_valid_o !== 1'b1 || rd_data_o !== m_rd_data) begin
        n_errors++;
        if (bad++ < 5)
          $display("FAIL stream_cycle%0d: count=%0d rv=%b data=%h, want 1023 1 %h",
                   i, count_o, rd_valid_o, rd_data_o, m_rd_data);
      end
    end
    n_checks++;
    if (overflow_o !== 1'b0 || underflow_o !== 1'b0 || drop_cnt_o !== 16'd0) begin
      n_errors++;
      $display("FAIL stream_flags: ovf=%b unf=%b drop=%0d want 0 0 0", overflow_o, underflow_o, drop_cnt_o);
    end
    $display("stream 2048 cycles count=%0d", count_o);
  endtask

  task automatic test_simultaneous();
    logic [31:0] first;
    do_reset();
    first = $urandom;
    cycle(1'b1, first, 1'b0, 1'b0);
    for (int i = 1; i < DEPTH; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, $urandom, 1'b1, 1'b0);
    n_checks++;
    if (count_o !== 11'd1023 || drop_cnt_o !== 16'd1 || overflow_o !== 1'b1 ||
        rd_valid_o !== 1'b1 || rd_data_o !== first) begin
      n_errors++;
      $display("FAIL full_wr_rd: count=%0d drop=%0d ovf=%b rv=%b data=%h, want 1023 1 1 1 %h",
               count_o, drop_cnt_o, overflow_o, rd_valid_o, rd_data_o, first);
    end
    do_reset();
    cycle(1'b1, $urandom, 1'b1, 1'b0);
    n_checks++;
    if (count_o !== 11'd1 || underflow_o !== 1'b1 || rd_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL empty_wr_rd: count=%0d unf=%b rv=%b, want 1 1 0", count_o, underflow_o, rd_valid_o);
    end
    $display("simultaneous wr/rd done");
  endtask

  // use_rst=0 flushes with clear_i, use_rst=1 with rst; both with traffic requested.
  task automatic test_flush(input bit use_rst);
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    rst = use_rst;
    cycle(1'b1, $urandom, 1'b1, !use_rst);
    rst = 1'b0;
    n_checks++;
    if (count_o !== 11'd0 || overflow_o !== 1'b0 || underflow_o !== 1'b0 || drop_cnt_o !== 16'd0 ||
        rd_valid_o !== 1'b0 || empty_o !== 1'b1 || rd_data_o !== 32'd0) begin
      n_errors++;
      $display("FAIL flush_%s: count=%0d ovf=%b unf=%b drop=%0d rv=%b empty=%b data=%h, want 0 0 0 0 0 1 0",
               use_rst ? "rst" : "clear", count_o, overflow_o, underflow_o, drop_cnt_o,
               rd_valid_o, empty_o, rd_data_o);
    end
    $display("flush via %s count=%0d", use_rst ? "rst" : "clear", count_o);
  endtask

  task automatic test_random();
    int bad = 0;
    bit v, r, c;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      v = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 999) == 0);
      cycle(v, $urandom, r, c);
      n_checks++;
      if (count_o !== 11'(mq.size()) || rd_valid_o !== m_rd_valid || rd_data_o !== m_rd_data ||
          overflow_o !== m_ovf || underflow_o !== m_unf || drop_cnt_o !== 16'(m_drop) ||
          empty_o !== (mq.size() == 0) || full_o !== (mq.size() == DEPTH)) begin
        n_errors++;
        if (bad++ < 5)
          $display("FAIL random_cycle%0d: count=%0d rv=%b data=%h ovf=%b unf=%b drop=%0d, want %0d %b %h %b %b %0d",
                   i, count_o, rd_valid_o, rd_data_o, overflow_o, underflow_o, drop_cnt_o,
                   mq.size(), m_rd_valid, m_rd_data, m_ovf, m_unf, m_drop);
      end
    end
    $display("random 4000 cycles final count=%0d", count_o);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_overflow();
    test_underflow();
    test_stream();
    test_simultaneous();
    test_flush(1'b0);
    test_flush(1'b1);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
